// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
// Pin-level sequencer for the multiplexed 8-bit address/data RTC port. Each
// accepted client enable runs one transaction: an address write followed by a
// data read. The client sees a DIR strobe, a DAT strobe and a field-done pulse.
// Optional build macro: RTC_BUS_WRITE_EN adds wr_mode/wr_data so that the data
// phase can drive a byte to the RTC instead of reading one.

module rtc_bus_sequencer #(
    parameter int T_PULSE = 4,
    parameter int T_GAP   = 2,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [7:0] addr,
`ifdef RTC_BUS_WRITE_EN
    input  logic       wr_mode,
    input  logic [7:0] wr_data,
`endif
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_sel,
    output logic       dir,
    output logic       dat,
    output logic       field_done,
    output logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DIR_PH   = 4'd1,
        S_A_SETUP  = 4'd2,
        S_A_STROBE = 4'd3,
        S_A_HOLD   = 4'd4,
        S_GAP      = 4'd5,
        S_D_STROBE = 4'd6,
        S_DAT_PH   = 4'd7,
        S_DONE     = 4'd8,
        S_WAIT_LOW = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((T_GAP > 0) ? (T_GAP - 1) : 0);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       rd_data_q;
    logic [7:0]       rd_data_d;

    // Registered pin and client outputs, each with its next-state value
    logic cs_n_q,     cs_n_d;
    logic rd_n_q,     rd_n_d;
    logic wr_n_q,     wr_n_d;
    logic ad_sel_q,   ad_sel_d;
    logic ad_oe_q,    ad_oe_d;
    logic addr_drv_q, addr_drv_d;
    logic wdat_drv_q, wdat_drv_d;
    logic dir_q,      dir_d;
    logic dat_q,      dat_d;
    logic done_q,     done_d;
    logic busy_q,     busy_d;

    // Write-phase selection; constant read-only in the default build
    logic       wr_active_s;
    logic [7:0] wr_data_s;

`ifdef RTC_BUS_WRITE_EN
    logic       wr_mode_q;
    logic [7:0] wr_data_q;

    // Capture the write request on the same edge that leaves IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_mode_q <= 1'b0;
            wr_data_q <= 8'h00;
        end else if ((state_q == S_IDLE) && req) begin
            wr_mode_q <= wr_mode;
            wr_data_q <= wr_data;
        end
    end

    assign wr_active_s = wr_mode_q;
    assign wr_data_s   = wr_data_q;
`else
    assign wr_active_s = 1'b0;
    assign wr_data_s   = 8'h00;
`endif

    // Next-state, phase counter and read-data capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = CNT_ZERO;
                if (req) begin
                    state_d = S_DIR_PH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIR_PH: begin
                state_d = S_A_SETUP;
                cnt_d   = CNT_ZERO;
            end
            S_A_SETUP: begin
                state_d = S_A_STROBE;
                cnt_d   = CNT_ZERO;
            end
            S_A_STROBE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_A_HOLD;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_A_HOLD: begin
                cnt_d = CNT_ZERO;
                if (T_GAP == 0) begin
                    state_d = S_D_STROBE;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_D_STROBE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_D_STROBE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_DAT_PH;
                    cnt_d   = CNT_ZERO;
                    // The bus is sampled on the edge that ends the read strobe
                    if (!wr_active_s) begin
                        rd_data_d = ad_in;
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DAT_PH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                // A held-high enable must drop before another field may start
                if (!req) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_LOW;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output values for the state about to be entered, so outputs can be registered
    always_comb begin
        cs_n_d     = 1'b1;
        rd_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        ad_sel_d   = 1'b0;
        ad_oe_d    = 1'b0;
        addr_drv_d = 1'b0;
        wdat_drv_d = 1'b0;
        dir_d      = 1'b0;
        dat_d      = 1'b0;
        done_d     = 1'b0;
        busy_d     = (state_d != S_IDLE);
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_DIR_PH: begin
                dir_d = 1'b1;
            end
            S_A_SETUP: begin
                ad_sel_d   = 1'b1;
                ad_oe_d    = 1'b1;
                addr_drv_d = 1'b1;
            end
            S_A_STROBE: begin
                ad_sel_d   = 1'b1;
                ad_oe_d    = 1'b1;
                addr_drv_d = 1'b1;
                cs_n_d     = 1'b0;
                wr_n_d     = 1'b0;
            end
            S_A_HOLD: begin
                // Address stays on the bus one cycle after the write strobe rises
                ad_sel_d   = 1'b1;
                ad_oe_d    = 1'b1;
                addr_drv_d = 1'b1;
            end
            S_GAP: begin
                ad_oe_d = 1'b0;
            end
            S_D_STROBE: begin
                cs_n_d = 1'b0;
                if (wr_active_s) begin
                    ad_oe_d    = 1'b1;
                    wdat_drv_d = 1'b1;
                    wr_n_d     = 1'b0;
                end else begin
                    // Bus released while the RTC drives it
                    ad_oe_d = 1'b0;
                    rd_n_d  = 1'b0;
                end
            end
            S_DAT_PH: begin
                dat_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            S_WAIT_LOW: begin
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Sequencer state, counter and registered outputs; reset forces strobes high at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_ZERO;
            rd_data_q  <= 8'h00;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            ad_sel_q   <= 1'b0;
            ad_oe_q    <= 1'b0;
            addr_drv_q <= 1'b0;
            wdat_drv_q <= 1'b0;
            dir_q      <= 1'b0;
            dat_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            ad_sel_q   <= ad_sel_d;
            ad_oe_q    <= ad_oe_d;
            addr_drv_q <= addr_drv_d;
            wdat_drv_q <= wdat_drv_d;
            dir_q      <= dir_d;
            dat_q      <= dat_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // The client's address register is loaded at the end of DIR_PH, so the
    // address byte is steered from the live addr input during the address phase.
    assign ad_out     = addr_drv_q ? addr : (wdat_drv_q ? wr_data_s : 8'h00);
    assign ad_oe      = ad_oe_q;
    assign cs_n       = cs_n_q;
    assign rd_n       = rd_n_q;
    assign wr_n       = wr_n_q;
    assign ad_sel     = ad_sel_q;
    assign dir        = dir_q;
    assign dat        = dat_q;
    assign field_done = done_q;
    assign rd_data    = rd_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer
// Directed bench: dut0 runs default timing, dut1 runs T_GAP=0 / T_PULSE=1.
// Build with RTC_BUS_WRITE_EN defined to include the write-phase scenario.

module tb_rtc_bus_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0, reset1, req0, req1;
    logic [7:0] addr, ad_in;
    logic [7:0] ad_out0, ad_out1, rd_data0, rd_data1;
    logic       ad_oe0, cs_n0, rd_n0, wr_n0, ad_sel0, dir0, dat0, field_done0, busy0;
    logic       ad_oe1, cs_n1, rd_n1, wr_n1, ad_sel1, dir1, dat1, field_done1, busy1;
`ifdef RTC_BUS_WRITE_EN
    logic       wr_mode0, wr_mode1;
    logic [7:0] wr_data0, wr_data1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    rtc_bus_sequencer dut0 (
        .clk(clk), .reset(reset0), .req(req0), .addr(addr),
`ifdef RTC_BUS_WRITE_EN
        .wr_mode(wr_mode0), .wr_data(wr_data0),
`endif
        .ad_in(ad_in), .ad_out(ad_out0), .ad_oe(ad_oe0), .cs_n(cs_n0),
        .rd_n(rd_n0), .wr_n(wr_n0), .ad_sel(ad_sel0), .dir(dir0), .dat(dat0),
        .field_done(field_done0), .rd_data(rd_data0), .busy(busy0)
    );

    rtc_bus_sequencer #(.T_PULSE(1), .T_GAP(0), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset1), .req(req1), .addr(addr),
`ifdef RTC_BUS_WRITE_EN
        .wr_mode(wr_mode1), .wr_data(wr_data1),
`endif
        .ad_in(ad_in), .ad_out(ad_out1), .ad_oe(ad_oe1), .cs_n(cs_n1),
        .rd_n(rd_n1), .wr_n(wr_n1), .ad_sel(ad_sel1), .dir(dir1), .dat(dat1),
        .field_done(field_done1), .rd_data(rd_data1), .busy(busy1)
    );

    task automatic test_reset();
        logic [25:0] got_v;
        reset0 = 1'b1; reset1 = 1'b1; req0 = 1'b0; req1 = 1'b0;
        addr = 8'h00; ad_in = 8'h00;
`ifdef RTC_BUS_WRITE_EN
        wr_mode0 = 1'b0; wr_mode1 = 1'b0; wr_data0 = 8'h00; wr_data1 = 8'h00;
`endif
        repeat (2) @(posedge clk);
        #1 reset0 = 1'b0; reset1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            got_v = {cs_n0, rd_n0, wr_n0, ad_oe0, busy0, dir0, dat0, field_done0, ad_sel0, ad_out0, rd_data0};
            n_cmp++;
            if (got_v !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
                n_err++;
                $display("FAIL reset_idle k=%0d got=%h required=%h", k, got_v,
                         {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
            end
        end
        n_cmp++;
        if ({cs_n1, rd_n1, wr_n1, ad_oe1, busy1, rd_data1} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_idle_fast got=%h required=%h",
                     {cs_n1, rd_n1, wr_n1, ad_oe1, busy1, rd_data1}, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
        end
    endtask

    task automatic test_single_read();
        logic [7:0] exp_v, got_v;
        @(posedge clk); #1 req0 = 1'b1; addr = 8'h00; ad_in = 8'h59;
        @(posedge clk);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            if (k == 1) addr = 8'h21;
            if (k == 15) req0 = 1'b0;
            @(negedge clk);
            exp_v = {k == 0, k == 13, k == 14,
                     !((k >= 2 && k <= 5) || (k >= 9 && k <= 12)),
                     !(k >= 2 && k <= 5), !(k >= 9 && k <= 12),
                     (k >= 1 && k <= 6), (k <= 15)};
            got_v = {dir0, dat0, field_done0, cs_n0, wr_n0, rd_n0, ad_oe0, busy0};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL read_phases k=%0d got=%b required=%b", k, got_v, exp_v);
            end
            if (k >= 2 && k <= 5) begin
                n_cmp++;
                if (ad_out0 !== 8'h21 || ad_sel0 !== 1'b1) begin
                    n_err++;
                    $display("FAIL addr_drive k=%0d got=%h/%b required=21/1", k, ad_out0, ad_sel0);
                end
            end
            if (k >= 9 && k <= 12) begin
                n_cmp++;
                if (ad_sel0 !== 1'b0) begin
                    n_err++;
                    $display("FAIL data_sel k=%0d got=%b required=0", k, ad_sel0);
                end
            end
            if (k == 12 || k == 13 || k == 14) begin
                n_cmp++;
                if (rd_data0 !== ((k == 12) ? 8'h00 : 8'h59)) begin
                    n_err++;
                    $display("FAIL rd_data k=%0d got=%h required=%h", k, rd_data0, (k == 12) ? 8'h00 : 8'h59);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] dv [3];
        logic [7:0] av [3];
        logic [7:0] prev;
        int dir_seen, dat_seen, conflict;
        bit done_seen;
        dv = '{8'h10, 8'h20, 8'h30};
        av = '{8'h40, 8'h41, 8'h42};
        prev = 8'h59;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 req0 = 1'b1; addr = av[i]; ad_in = dv[i];
            dir_seen = 0; dat_seen = 0; conflict = 0; done_seen = 1'b0;
            for (int c = 0; c < 40 && !done_seen; c++) begin
                @(negedge clk);
                if (dir0) begin
                    dir_seen++;
                    n_cmp++;
                    if (rd_data0 !== prev) begin
                        n_err++;
                        $display("FAIL b2b_hold field=%0d got=%h required=%h", i, rd_data0, prev);
                    end
                end
                if (dat0) begin
                    dat_seen++;
                    n_cmp++;
                    if (rd_data0 !== dv[i]) begin
                        n_err++;
                        $display("FAIL b2b_data field=%0d got=%h required=%h", i, rd_data0, dv[i]);
                    end
                end
                if (ad_oe0 && !rd_n0) conflict++;
                if (field_done0) done_seen = 1'b1;
            end
            n_cmp++;
            if (!done_seen || dir_seen != 1 || dat_seen != 1 || conflict != 0) begin
                n_err++;
                $display("FAIL b2b_field field=%0d got done=%0d dir=%0d dat=%0d conflict=%0d required 1/1/1/0",
                         i, done_seen, dir_seen, dat_seen, conflict);
            end
            prev = dv[i];
            @(posedge clk); #1 req0 = 1'b0;
        end
    endtask

    task automatic test_hold_high();
        bit done_seen;
        int bad;
        @(posedge clk); #1 req0 = 1'b1; addr = 8'h0B; ad_in = 8'h77;
        done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(negedge clk);
            if (field_done0) done_seen = 1'b1;
        end
        n_cmp++;
        if (!done_seen) begin
            n_err++;
            $display("FAIL hold_done got=timeout required=field_done");
        end
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (dir0 !== 1'b0 || busy0 !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL hold_wait_low got=%0d bad cycles required=0", bad);
        end
        @(posedge clk); #1 req0 = 1'b0;
        @(posedge clk); #1 req0 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy0, dir0} !== 2'b00) begin
            n_err++;
            $display("FAIL hold_rearm_idle got=%b required=00", {busy0, dir0});
        end
        @(negedge clk);
        n_cmp++;
        if (dir0 !== 1'b1) begin
            n_err++;
            $display("FAIL hold_rearm_dir got=%b required=1", dir0);
        end
        done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(negedge clk);
            if (field_done0) done_seen = 1'b1;
        end
        n_cmp++;
        if (!done_seen) begin
            n_err++;
            $display("FAIL hold_second_done got=timeout required=field_done");
        end
        @(posedge clk); #1 req0 = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        bit found;
        @(posedge clk); #1 req0 = 1'b1; addr = 8'h0C; ad_in = 8'h3C;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (rd_n0 === 1'b0) found = 1'b1;
        end
        n_cmp++;
        if (!found || rd_data0 !== 8'h77) begin
            n_err++;
            $display("FAIL rst_reach_dstrobe got found=%0d rd_data=%h required 1/77", found, rd_data0);
        end
        #1 reset0 = 1'b1;
        #1;
        n_cmp++;
        if ({rd_n0, cs_n0, wr_n0, ad_oe0, busy0, rd_data0} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL rst_async got=%h required=%h",
                     {rd_n0, cs_n0, wr_n0, ad_oe0, busy0, rd_data0}, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
        end
        req0 = 1'b0;
        @(posedge clk); #1 reset0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy0, dir0, cs_n0, rd_n0, ad_oe0, rd_data0} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
                n_err++;
                $display("FAIL rst_idle k=%0d got=%h required=%h", k,
                         {busy0, dir0, cs_n0, rd_n0, ad_oe0, rd_data0}, {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
            end
        end
    endtask

    task automatic test_fast_timing();
        logic [7:0] exp_v, got_v;
        @(posedge clk); #1 req1 = 1'b1; addr = 8'h00; ad_in = 8'hC3;
        @(posedge clk);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            if (k == 1) addr = 8'h5A;
            if (k == 7) req1 = 1'b0;
            @(negedge clk);
            exp_v = {k == 0, k == 5, k == 6, !(k == 2 || k == 4), !(k == 2), !(k == 4),
                     (k >= 1 && k <= 3), (k <= 7)};
            got_v = {dir1, dat1, field_done1, cs_n1, wr_n1, rd_n1, ad_oe1, busy1};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL fast_phases k=%0d got=%b required=%b", k, got_v, exp_v);
            end
            if (ad_oe1 && !rd_n1) begin
                n_err++;
                $display("FAIL fast_conflict k=%0d got ad_oe=1 rd_n=0 required no overlap", k);
            end
            if (k == 2) begin
                n_cmp++;
                if (ad_out1 !== 8'h5A) begin
                    n_err++;
                    $display("FAIL fast_addr got=%h required=5a", ad_out1);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (rd_data1 !== 8'hC3) begin
                    n_err++;
                    $display("FAIL fast_rd_data got=%h required=c3", rd_data1);
                end
            end
        end
    endtask

`ifdef RTC_BUS_WRITE_EN
    task automatic test_write_mode();
        logic [3:0] got_v;
        @(posedge clk); #1 req1 = 1'b1; wr_mode1 = 1'b1; wr_data1 = 8'hA5; addr = 8'h5B; ad_in = 8'h99;
        @(posedge clk);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            if (k == 0) begin
                wr_mode1 = 1'b0;
                wr_data1 = 8'h00;
            end
            if (k == 7) req1 = 1'b0;
            @(negedge clk);
            if (k == 4) begin
                got_v = {wr_n1, rd_n1, cs_n1, ad_oe1};
                n_cmp++;
                if (got_v !== 4'b0101 || ad_out1 !== 8'hA5) begin
                    n_err++;
                    $display("FAIL write_phase got=%b/%h required=0101/a5", got_v, ad_out1);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (dat1 !== 1'b1 || rd_data1 !== 8'hC3) begin
                    n_err++;
                    $display("FAIL write_keep_rd got dat=%b rd_data=%h required 1/c3", dat1, rd_data1);
                end
            end
            if (k == 6) begin
                n_cmp++;
                if (field_done1 !== 1'b1) begin
                    n_err++;
                    $display("FAIL write_done got=%b required=1", field_done1);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_hold_high();
        test_reset_mid();
        test_fast_timing();
`ifdef RTC_BUS_WRITE_EN
        test_write_mode();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
